// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared pipeline types and constants for hazard detection and forwarding select
package hazard_unit_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int X0_ADDR    = 0;

   typedef enum logic {
      IDLE,
      DIV_WAIT
   } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - decode rs1/rs2/rd compare against one producer destination, gated by use flags
module hazard_match
   import hazard_unit_pkg::*;
#(
   parameter int R = REG_ADDR_W
) (
   input  logic [R-1:0] src1,
   input  logic [R-1:0] src2,
   input  logic [R-1:0] dst,
   input  logic         use_src1,
   input  logic         use_src2,
   input  logic         chk_waw,
   input  logic [R-1:0] tgt_rd,
   output logic         hit
);

   // a producer writing x0 never blocks anything
   assign hit = (tgt_rd != R'(X0_ADDR)) &&
                ((use_src1 && (src1 == tgt_rd)) ||
                 (use_src2 && (src2 == tgt_rd)) ||
                 (chk_waw  && (dst  == tgt_rd)));

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use and divide hazard stall/flush control; HAZARD_DIV_OOO_EN lets independent work pass a pending divide
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int R     = REG_ADDR_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             a_reset_n,
   input  logic             dec_valid,
   input  logic [R-1:0]     dec_addr1,
   input  logic [R-1:0]     dec_addr2,
   input  logic [R-1:0]     dec_rd,
   input  logic             useLhs,
   input  logic             useRhs,
   input  logic             useData,
   input  logic             dec_is_div,
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic             ex_is_div,
   input  logic [R-1:0]     ex_rd,
   input  logic             div_done,
   input  logic             branch_taken,
   output logic             stall_if,
   output logic             stall_dec,
   output logic             bubble_ex,
   output logic             flush_dec,
   output logic             div_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   hz_state_t    state, state_nxt;
   logic [R-1:0] div_rd, div_rd_nxt;
   logic         use2, load_hit, luse, ex_div, div_start;
   logic         ex_dhaz, wait_dhaz, stall;

   assign use2 = useRhs | useData;

   hazard_match #(.R(R)) u_load_match (
      .src1(dec_addr1), .src2(dec_addr2), .dst(dec_rd),
      .use_src1(useLhs), .use_src2(use2), .chk_waw(1'b0),
      .tgt_rd(ex_rd), .hit(load_hit)
   );

   assign luse      = ex_valid && ex_is_load && dec_valid && load_hit;
   assign ex_div    = ex_valid && ex_is_div;
   assign div_start = ex_div && !branch_taken;

`ifdef HAZARD_DIV_OOO_EN
   logic exdiv_hit, divrd_hit;

   hazard_match #(.R(R)) u_exdiv_match (
      .src1(dec_addr1), .src2(dec_addr2), .dst(dec_rd),
      .use_src1(useLhs), .use_src2(use2), .chk_waw(1'b1),
      .tgt_rd(ex_rd), .hit(exdiv_hit)
   );

   hazard_match #(.R(R)) u_divrd_match (
      .src1(dec_addr1), .src2(dec_addr2), .dst(dec_rd),
      .use_src1(useLhs), .use_src2(use2), .chk_waw(1'b1),
      .tgt_rd(div_rd), .hit(divrd_hit)
   );

   // a second divide must wait for the single divider even with no register overlap
   assign ex_dhaz   = ex_div && dec_valid && (exdiv_hit || dec_is_div);
   assign wait_dhaz = (state == DIV_WAIT) && dec_valid && (divrd_hit || dec_is_div);
`else
   logic unused_dec_is_div;

   assign unused_dec_is_div = dec_is_div;
   assign ex_dhaz   = ex_div && dec_valid;
   assign wait_dhaz = (state == DIV_WAIT) && dec_valid;
`endif

   assign stall     = (luse || ex_dhaz || wait_dhaz) && !branch_taken;
   assign stall_if  = stall;
   assign stall_dec = stall;
   assign bubble_ex = stall;
   assign flush_dec = branch_taken;
   assign div_busy  = (state == DIV_WAIT);

   always_comb begin
      state_nxt  = state;
      div_rd_nxt = div_rd;
      case (state)
         IDLE: begin
            if (div_start) begin
               state_nxt  = DIV_WAIT;
               div_rd_nxt = ex_rd;
            end
         end
         DIV_WAIT: begin
            // back-to-back divide: the new one takes over the busy window
            if (div_done) begin
               if (div_start) begin
                  div_rd_nxt = ex_rd;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         state     <= IDLE;
         div_rd    <= '0;
         stall_cnt <= '0;
      end else begin
         state  <= state_nxt;
         div_rd <= div_rd_nxt;
         if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
module tb_hazard_unit;

   localparam int R     = 5;
   localparam int CNT_W = 4;
`ifdef HAZARD_DIV_OOO_EN
   localparam logic OOO = 1'b1;
`else
   localparam logic OOO = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             a_reset_n;
   logic             dec_valid, useLhs, useRhs, useData, dec_is_div;
   logic [R-1:0]     dec_addr1, dec_addr2, dec_rd, ex_rd;
   logic             ex_valid, ex_is_load, ex_is_div, div_done, branch_taken;
   logic             stall_if, stall_dec, bubble_ex, flush_dec, div_busy;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      string            tag;
      logic             stall;
      logic             flush;
      logic             busy;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             exp_q[$];
   logic [CNT_W-1:0] cnt_model = '0;
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   hazard_unit #(.R(R), .CNT_W(CNT_W)) dut (
      .clk(clk), .a_reset_n(a_reset_n),
      .dec_valid(dec_valid), .dec_addr1(dec_addr1), .dec_addr2(dec_addr2), .dec_rd(dec_rd),
      .useLhs(useLhs), .useRhs(useRhs), .useData(useData), .dec_is_div(dec_is_div),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_div(ex_is_div), .ex_rd(ex_rd),
      .div_done(div_done), .branch_taken(branch_taken),
      .stall_if(stall_if), .stall_dec(stall_dec), .bubble_ex(bubble_ex),
      .flush_dec(flush_dec), .div_busy(div_busy), .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_dec(input logic v, input logic [R-1:0] a1, input logic [R-1:0] a2,
                          input logic [R-1:0] rd, input logic ul, input logic ur,
                          input logic ud, input logic dv);
      dec_valid = v; dec_addr1 = a1; dec_addr2 = a2; dec_rd = rd;
      useLhs = ul; useRhs = ur; useData = ud; dec_is_div = dv;
   endtask

   task automatic set_ex(input logic v, input logic ld, input logic dv, input logic [R-1:0] rd);
      ex_valid = v; ex_is_load = ld; ex_is_div = dv; ex_rd = rd;
   endtask

   // called just after a rising edge with inputs already driven; outputs checked at the falling edge
   task automatic step(input string tag, input logic e_stall, input logic e_flush, input logic e_busy);
      exp_t e;
      e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.busy = e_busy; e.cnt = cnt_model;
      exp_q.push_back(e);
      if (e_stall && a_reset_n) cnt_model = (cnt_model == {CNT_W{1'b1}}) ? cnt_model : cnt_model + 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      check({e.tag, ".stall_if"},  32'(stall_if),  32'(e.stall));
      check({e.tag, ".stall_dec"}, 32'(stall_dec), 32'(e.stall));
      check({e.tag, ".bubble_ex"}, 32'(bubble_ex), 32'(e.stall));
      check({e.tag, ".flush_dec"}, 32'(flush_dec), 32'(e.flush));
      check({e.tag, ".div_busy"},  32'(div_busy),  32'(e.busy));
      check({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_reset_n = 1'b0;
      div_done = 1'b0; branch_taken = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_ex(0, 0, 0, 0);
      step("reset", 0, 0, 0);
      a_reset_n = 1'b1;
      step("idle", 0, 0, 0);

      // load-use on rs1: one stall, then the bubble releases it
      set_ex(1, 1, 0, 5); set_dec(1, 5, 0, 6, 1, 0, 0, 0);
      step("luse_rs1", 1, 0, 0);
      set_ex(0, 0, 0, 0);
      step("luse_after", 0, 0, 0);

      set_ex(1, 1, 0, 0); set_dec(1, 0, 0, 6, 1, 1, 0, 0);
      step("luse_x0", 0, 0, 0);
      set_ex(1, 1, 0, 5); set_dec(1, 0, 5, 6, 0, 0, 1, 0);
      step("luse_data", 1, 0, 0);
      set_dec(1, 0, 5, 6, 0, 0, 0, 0);
      step("luse_nouse", 0, 0, 0);
      set_dec(0, 5, 5, 6, 1, 1, 0, 0);
      step("luse_decinv", 0, 0, 0);

      set_dec(1, 5, 0, 6, 1, 0, 0, 0); branch_taken = 1'b1;
      step("luse_branch", 0, 1, 0);
      set_ex(1, 0, 1, 7);
      step("div_branch", 0, 1, 0);
      branch_taken = 1'b0; set_ex(0, 0, 0, 0);
      step("div_branch_next", 0, 0, 0);

      // divide on x7 with a dependent reader; counter saturates during the wait
      set_ex(1, 0, 1, 7); set_dec(1, 7, 0, 8, 1, 0, 0, 0);
      step("div_enter", 1, 0, 0);
      set_ex(0, 0, 0, 0);
      for (int i = 0; i < 33; i++) step("div_wait", 1, 0, 1);
      div_done = 1'b1;
      step("div_done", 1, 0, 1);
      div_done = 1'b0;
      step("div_release", 0, 0, 0);

      // independent vs dependent work while a divide is pending
      set_ex(1, 0, 1, 7); set_dec(1, 1, 2, 3, 1, 1, 0, 0);
      step("ooo_enter", !OOO, 0, 0);
      set_ex(0, 0, 0, 0);
      step("ooo_indep", !OOO, 0, 1);
      set_dec(1, 1, 0, 7, 1, 0, 0, 0);
      step("ooo_waw", 1, 0, 1);
      set_dec(1, 0, 0, 0, 1, 0, 0, 0);
      step("ooo_rd_x0", !OOO, 0, 1);
      set_dec(1, 1, 2, 3, 1, 1, 0, 1);
      step("ooo_dec_div", 1, 0, 1);
      div_done = 1'b1; set_ex(1, 0, 1, 9); set_dec(1, 1, 2, 3, 1, 1, 0, 0);
      step("done_new_div", !OOO, 0, 1);
      div_done = 1'b0; set_ex(0, 0, 0, 0); set_dec(1, 9, 0, 4, 1, 0, 0, 0);
      step("new_div_dep", 1, 0, 1);
      div_done = 1'b1;
      step("new_div_done", 1, 0, 1);
      div_done = 1'b0;
      step("new_div_release", 0, 0, 0);

      // reset in the middle of a divide, then a stray completion
      set_ex(1, 0, 1, 7); set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      step("rst_div_enter", 0, 0, 0);
      set_ex(0, 0, 0, 0);
      step("rst_div_wait", 0, 0, 1);
      a_reset_n = 1'b0;
      #2;
      check("rst_async.div_busy",  32'(div_busy),  32'd0);
      check("rst_async.stall_cnt", 32'(stall_cnt), 32'd0);
      a_reset_n = 1'b1;
      cnt_model = '0;
      div_done = 1'b1; set_dec(1, 7, 0, 8, 1, 0, 0, 0);
      step("stray_done", 0, 0, 0);
      div_done = 1'b0;
      step("after_stray", 0, 0, 0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
